decode_out: RTL and testbench

DECODE_OUT -- requirements
Module: decode_out

---
 rtl/decode_out.sv | 160 ++++++++++++++++
 tb/tb_decode_out.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_out.sv
// rtl/decode_out.sv - packs decoded bytes into 64-bit words behind a 2-entry FIFO
// Optional running byte checksum port enabled by DECODE_OUT_CHKSUM_EN.
module decode_out #(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           out_data,
  input  logic                 out_valid,
  input  logic                 out_done,
  output logic                 fo_full,
  output logic [63:0]          m_dst,
  output logic                 m_dst_putn,
  output logic [3:0]           m_dst_bytes,
  output logic                 m_dst_last,
  input  logic                 m_dst_full,
  output logic [LZF_WIDTH-1:0] dst_cnt,
  output logic                 done
`ifdef DECODE_OUT_CHKSUM_EN
  ,
  output logic [31:0]          chksum
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_e;

  // FIFO entry layout: {last, bytes[3:0], data[63:0]}
  state_e                 state_q, state_d;
  logic [2:0]             pack_cnt_q, pack_cnt_d;
  logic [63:0]            pack_q, pack_d;
  logic [68:0]            fifo0_q, fifo0_d;
  logic [68:0]            fifo1_q, fifo1_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [LZF_WIDTH-1:0]   dst_cnt_q, dst_cnt_d;
  logic                   done_q, done_d;
`ifdef DECODE_OUT_CHKSUM_EN
  logic [31:0]            chksum_q, chksum_d;
`endif

  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   push_ok;
  logic [68:0]            entry;
  logic [68:0]            head;
  logic [63:0]            word_w;

  assign head   = rd_ptr_q ? fifo1_q : fifo0_q;
  assign pop    = (cnt_q != 2'd0) && !m_dst_full;
  assign accept = (state_q == S_RUN) && out_valid;

  always_comb begin
    state_d    = state_q;
    pack_cnt_d = pack_cnt_q;
    pack_d     = pack_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dst_cnt_d  = dst_cnt_q;
`ifdef DECODE_OUT_CHKSUM_EN
    chksum_d   = chksum_q;
`endif
    push       = 1'b0;
    entry      = '0;
    word_w     = pack_q;
    word_w[{pack_cnt_q, 3'b000} +: 8] = out_data;

    case (state_q)
      S_RUN: begin
        if (accept) begin
          dst_cnt_d = dst_cnt_q + LZF_WIDTH'(1);
`ifdef DECODE_OUT_CHKSUM_EN
          chksum_d  = chksum_q + {24'd0, out_data};
`endif
          if (pack_cnt_q == 3'd7) begin
            push       = 1'b1;
            entry      = {1'b0, 4'd8, word_w};
            pack_d     = '0;
            pack_cnt_d = 3'd0;
          end else begin
            pack_d     = word_w;
            pack_cnt_d = pack_cnt_q + 3'd1;
          end
        end
        if (out_done) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // pack_cnt of 0 yields the empty terminator word
        if (cnt_q != 2'd2) begin
          push       = 1'b1;
          entry      = {1'b1, 1'b0, pack_cnt_q, pack_q};
          pack_d     = '0;
          pack_cnt_d = 3'd0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) state_d = S_DONE;
      end
      default: ;
    endcase

    push_ok = push && ((cnt_q != 2'd2) || pop);
    if (push_ok) begin
      if (wr_ptr_q) fifo1_d = entry;
      else          fifo0_d = entry;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d  = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pack_cnt_q <= 3'd0;
      pack_q     <= '0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      dst_cnt_q  <= '0;
      done_q     <= 1'b0;
`ifdef DECODE_OUT_CHKSUM_EN
      chksum_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pack_cnt_q <= pack_cnt_d;
      pack_q     <= pack_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      dst_cnt_q  <= dst_cnt_d;
      done_q     <= done_d;
`ifdef DECODE_OUT_CHKSUM_EN
      chksum_q   <= chksum_d;
`endif
    end
  end

  assign fo_full     = (cnt_q == 2'd2);
  assign m_dst_putn  = ~pop;
  assign m_dst       = pop ? head[63:0]  : 64'd0;
  assign m_dst_bytes = pop ? head[67:64] : 4'd0;
  assign m_dst_last  = pop ? head[68]    : 1'b0;
  assign dst_cnt     = dst_cnt_q;
  assign done        = done_q;
`ifdef DECODE_OUT_CHKSUM_EN
  assign chksum      = chksum_q;
`endif

endmodule

// File: tb/tb_decode_out.sv
// tb/tb_decode_out.sv - directed scoreboard bench for decode_out
module tb_decode_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  out_data = 8'd0;
  logic        out_valid = 1'b0;
  logic        out_done = 1'b0;
  logic        fo_full;
  logic [63:0] m_dst;
  logic        m_dst_putn;
  logic [3:0]  m_dst_bytes;
  logic        m_dst_last;
  logic        m_dst_full = 1'b0;
  logic [19:0] dst_cnt;
  logic        done;
`ifdef DECODE_OUT_CHKSUM_EN
  logic [31:0] chksum;
`endif

  decode_out #(.LZF_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .out_data(out_data), .out_valid(out_valid),
    .out_done(out_done), .fo_full(fo_full), .m_dst(m_dst),
    .m_dst_putn(m_dst_putn), .m_dst_bytes(m_dst_bytes), .m_dst_last(m_dst_last),
    .m_dst_full(m_dst_full), .dst_cnt(dst_cnt), .done(done)
`ifdef DECODE_OUT_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_pass = 0;
  int    n_chk = 0;
  logic  started = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [3:0] b, input logic l);
    word_t w;
    w.data = d; w.bytes = b; w.last = l;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every write strobe must match the oldest expected word
  always @(negedge clk) begin
    if (started && !rst) begin
      if (m_dst_putn === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 64'(m_dst_putn), 64'd1);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("word_data", m_dst, e.data);
          chk("word_bytes", 64'(m_dst_bytes), 64'(e.bytes));
          chk("word_last", 64'(m_dst_last), 64'(e.last));
        end
      end else begin
        chk("idle_outputs_zero", m_dst | 64'({m_dst_bytes, m_dst_last}), 64'd0);
      end
      if (out_valid && fo_full) chk("contract_valid_while_full", 64'(out_valid), 64'd0);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic dn);
    @(posedge clk);
    #1;
    out_valid = v;
    out_data  = d;
    out_done  = dn;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; out_valid = 1'b0; out_done = 1'b0; out_data = 8'd0; m_dst_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_pulse(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (m_dst_putn !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(m_dst_putn), 64'd0);
  endtask

  task automatic send_word(input logic [7:0] base, input logic last_done);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = base + 8'(i);
      drive(1'b1, base + 8'(i), (i == 7) ? last_done : 1'b0);
    end
    push_exp(w, 4'd8, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_putn", 64'(m_dst_putn), 64'd1);
    chk("rst_m_dst", m_dst, 64'd0);
    chk("rst_bytes", 64'(m_dst_bytes), 64'd0);
    chk("rst_last", 64'(m_dst_last), 64'd0);
    chk("rst_dst_cnt", 64'(dst_cnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fo_full", 64'(fo_full), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    // Eight bytes 0x01..0x08, one-cycle latency to the strobe
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0);
    push_exp(64'h0807060504030201, 4'd8, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    chk("latency_putn", 64'(m_dst_putn), 64'd0);
    chk("cnt8_dst_cnt", 64'(dst_cnt), 64'd8);
    wait_drain("drain_basic");

    // Partial word AA BB CC then out_done
    do_reset();
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    drive(1'b1, 8'hCC, 1'b0);
    drive(1'b0, 8'd0, 1'b1);
    push_exp(64'h0000000000CCBBAA, 4'd3, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    wait_pulse("partial_pulse");
    chk("partial_done_low_at_pulse", 64'(done), 64'd0);
    @(negedge clk);
    chk("partial_done_next", 64'(done), 64'd1);
    chk("partial_dst_cnt", 64'(dst_cnt), 64'd3);
    drive(1'b1, 8'h55, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_held", 64'(done), 64'd1);
    chk("done_cnt_frozen", 64'(dst_cnt), 64'd3);

    // Backpressure: 16 bytes against a full sink
    do_reset();
    drive(1'b0, 8'd0, 1'b0);
    m_dst_full = 1'b1;
    for (int h = 0; h < 2; h++) begin
      w = '0;
      for (int i = 0; i < 8; i++) begin
        w[8*i +: 8] = 8'h10 + 8'(8*h + i);
        drive(1'b1, 8'h10 + 8'(8*h + i), 1'b0);
        if (h == 1 && i == 0) begin
          @(negedge clk);
          chk("bp_fo_full_one_word", 64'(fo_full), 64'd0);
        end
      end
      push_exp(w, 4'd8, 1'b0);
    end
    drive(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    chk("bp_fo_full_two_words", 64'(fo_full), 64'd1);
    chk("bp_no_write_when_full", 64'(m_dst_putn), 64'd1);
    repeat (2) @(negedge clk);
    chk("bp_fo_full_held", 64'(fo_full), 64'd1);
    @(posedge clk);
    #1;
    m_dst_full = 1'b0;
    @(negedge clk);
    chk("bp_pulse1", 64'(m_dst_putn), 64'd0);
    @(negedge clk);
    chk("bp_pulse2", 64'(m_dst_putn), 64'd0);
    @(negedge clk);
    chk("bp_after_pulses", 64'(m_dst_putn), 64'd1);
    chk("bp_fo_full_clear", 64'(fo_full), 64'd0);
    drive(1'b0, 8'd0, 1'b1);
    push_exp(64'd0, 4'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    wait_drain("drain_bp");
    @(negedge clk);
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_dst_cnt", 64'(dst_cnt), 64'd16);

    // Eighth byte coincides with out_done
    do_reset();
    send_word(8'h21, 1'b1);
    push_exp(64'd0, 4'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    wait_drain("drain_coincide");
    @(negedge clk);
    chk("coincide_done", 64'(done), 64'd1);
    chk("coincide_dst_cnt", 64'(dst_cnt), 64'd8);

    // Reset mid-stream discards the partial word
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h31 + 8'(i), 1'b0);
    @(posedge clk);
    #1;
    out_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_putn", 64'(m_dst_putn), 64'd1);
    chk("midrst_dst_cnt", 64'(dst_cnt), 64'd0);
    chk("midrst_fo_full", 64'(fo_full), 64'd0);
    send_word(8'h41, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    wait_drain("drain_midrst");
    chk("midrst_new_cnt", 64'(dst_cnt), 64'd8);

`ifdef DECODE_OUT_CHKSUM_EN
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF, 1'b0);
    drive(1'b0, 8'd0, 1'b1);
    push_exp(64'h00000000FFFFFFFF, 4'd4, 1'b1);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    wait_drain("drain_chksum");
    chk("chksum_value", 64'(chksum), 64'h3FC);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
